taillight_sequencer: RTL

Self-contained controller for the '65 Thunderbird taillight lamps: takes raw left, right, hazard and brake switches, synchronizes and debounces them, and arbitrates between turn and hazard requests. It sequences the six lamps with an internal tick prescaler, so no separate scaled clock is needed. It drives la/lb/lc/ra/rb/rc directly from the system clock domain and sits between the board switches and the lamp pins.

---
 rtl/taillight_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/taillight_sequencer.sv
// Thunderbird taillight controller: synchronizes and debounces the four raw
// switches, steps a turn/hazard sequencer on an internal prescaler tick and
// drives the six lamps (with brake overlay) from registered outputs.
module taillight_sequencer #(
  parameter int TICK_DIV  = 12_500_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left,
  input  logic       right,
  input  logic       hazard,
  input  logic       brake,
  output logic       la,
  output logic       lb,
  output logic       lc,
  output logic       ra,
  output logic       rb,
  output logic       rc,
  output logic       busy,
  output logic [3:0] dbg_state_o
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);
  localparam logic [DW-1:0] DB_ONE    = DW'(1);

  // Bit positions of the switches inside the 4-bit switch vectors.
  localparam int IDX_L = 0;
  localparam int IDX_R = 1;
  localparam int IDX_H = 2;
  localparam int IDX_B = 3;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_L1      = 4'd1,
    S_L2      = 4'd2,
    S_L3      = 4'd3,
    S_R1      = 4'd4,
    S_R2      = 4'd5,
    S_R3      = 4'd6,
    S_HAZ_ON  = 4'd7,
    S_HAZ_OFF = 4'd8
  } state_t;

  logic [3:0]    raw_w;
  logic [3:0]    sync1_q, sync2_q;
  logic [DW-1:0] db_cnt_q [4];
  logic [DW-1:0] db_cnt_d [4];
  logic [3:0]    deb_q, deb_d;
  logic [TW-1:0] pre_q, pre_d;
  logic          tick;
  logic          haz_req;
  state_t        state_q, state_d;
  logic [5:0]    lamps_q, lamps_d;   // {la, lb, lc, ra, rb, rc}
  logic          busy_q, busy_d;

  assign raw_w = {brake, hazard, right, left};

  // Two-flop synchronizer for all four raw switches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_w;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: a switch change is accepted only after DB_CYCLES consecutive
  // clocks in which the synchronized value differs from the accepted one.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_q <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      deb_q <= deb_d;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  // Free-running prescaler; tick marks the last count of each period.
  assign tick = (pre_q == TICK_LAST);

  always_comb begin
    pre_d = tick ? '0 : pre_q + TICK_ONE;
  end

  // Prescaler register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pre_q <= '0;
    else       pre_q <= pre_d;
  end

  // Both turn switches together count as a hazard request.
  assign haz_req = deb_q[IDX_H] | (deb_q[IDX_L] & deb_q[IDX_R]);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state: only moves on tick; hazard preempts any turn step.
  always_comb begin
    state_d = state_q;
    if (tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (haz_req)           state_d = S_HAZ_ON;
          else if (deb_q[IDX_L]) state_d = S_L1;
          else if (deb_q[IDX_R]) state_d = S_R1;
        end
        S_L1:      state_d = haz_req ? S_HAZ_ON : S_L2;
        S_L2:      state_d = haz_req ? S_HAZ_ON : S_L3;
        S_L3:      state_d = haz_req ? S_HAZ_ON : S_IDLE;
        S_R1:      state_d = haz_req ? S_HAZ_ON : S_R2;
        S_R2:      state_d = haz_req ? S_HAZ_ON : S_R3;
        S_R3:      state_d = haz_req ? S_HAZ_ON : S_IDLE;
        S_HAZ_ON:  state_d = S_HAZ_OFF;
        S_HAZ_OFF: state_d = haz_req ? S_HAZ_ON : S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Lamp pattern from state, with brake lighting the side not in use.
  always_comb begin
    lamps_d = 6'b000000;
    busy_d  = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE:    lamps_d = {6{deb_q[IDX_B]}};
      S_L1:      lamps_d = {3'b100, {3{deb_q[IDX_B]}}};
      S_L2:      lamps_d = {3'b110, {3{deb_q[IDX_B]}}};
      S_L3:      lamps_d = {3'b111, {3{deb_q[IDX_B]}}};
      S_R1:      lamps_d = {{3{deb_q[IDX_B]}}, 3'b100};
      S_R2:      lamps_d = {{3{deb_q[IDX_B]}}, 3'b110};
      S_R3:      lamps_d = {{3{deb_q[IDX_B]}}, 3'b111};
      S_HAZ_ON:  lamps_d = 6'b111111;
      S_HAZ_OFF: lamps_d = 6'b000000;
      default:   lamps_d = 6'b000000;
    endcase
  end

  // Registered lamp and busy outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lamps_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      lamps_q <= lamps_d;
      busy_q  <= busy_d;
    end
  end

  assign {la, lb, lc, ra, rb, rc} = lamps_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule
